// File: rtl/countdown_timer_bcd.sv
// -----------------------------------------------------------------------------
// countdown_timer_bcd
//   BCD countdown timer (MM:SS.cc) with a borrow chain. Loaded with minutes and
//   seconds, it counts down one centisecond per clock and raises a one-cycle
//   done pulse plus an ALARM_LEN-cycle alarm when it reaches 00:00.00.
//
// State table
//   state      | meaning
//   ST_IDLE    | loaded or reset, waiting for start
//   ST_RUN     | decrementing one centisecond per edge
//   ST_PAUSED  | count frozen, waiting for start (resume) or load
//   ST_EXPIRED | count reached zero; alarm timer may still be running
//
// Ports
//   i_clk100hz  in   1  100 Hz clock, all state updates on rising edge
//   i_rst       in   1  synchronous reset, active-high
//   i_load      in   1  load i_min_in/i_sec_in (not in RUN)
//   i_min_in    in   8  BCD minutes {tens,units}
//   i_sec_in    in   8  BCD seconds {tens,units}
//   i_start     in   1  start/resume countdown
//   i_pause     in   1  freeze countdown
//   o_min       out  8  BCD minutes remaining
//   o_sec       out  8  BCD seconds remaining
//   o_cs        out  8  BCD centiseconds remaining
//   o_running   out  1  high while in RUN
//   o_done      out  1  one-cycle pulse on expiry
//   o_alarm     out  1  high ALARM_LEN cycles starting with done
// -----------------------------------------------------------------------------
module countdown_timer_bcd #(
    parameter int ALARM_LEN = 100
) (
    input  logic       i_clk100hz,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_min_in,
    input  logic [7:0] i_sec_in,
    input  logic       i_start,
    input  logic       i_pause,
    output logic [7:0] o_min,
    output logic [7:0] o_sec,
    output logic [7:0] o_cs,
    output logic       o_running,
    output logic       o_done,
    output logic       o_alarm
);

    // Alarm down-counter holds ALARM_LEN-1 .. 0, so clog2(ALARM_LEN) bits suffice.
    localparam int CW = (ALARM_LEN > 1) ? $clog2(ALARM_LEN) : 1;
    localparam logic [CW-1:0] ALARM_RELOAD = CW'(ALARM_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t        r_state,     w_state_nxt;
    logic [7:0]    r_min,       w_min_nxt;
    logic [7:0]    r_sec,       w_sec_nxt;
    logic [7:0]    r_cs,        w_cs_nxt;
    logic          r_done,      w_done_nxt;
    logic          r_alarm,     w_alarm_nxt;
    logic [CW-1:0] r_alarm_cnt, w_alarm_cnt_nxt;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

    // Decrement a {tens,units} BCD pair; 00 wraps to {tens_max,9}.
    function automatic logic [7:0] dec_pair(input logic [7:0] v, input logic [3:0] tens_max);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = v[7:4];
        units = v[3:0];
        if (units != 4'd0) begin
            units = units - 4'd1;
        end else begin
            units = 4'd9;
            tens  = (tens == 4'd0) ? tens_max : tens - 4'd1;
        end
        return {tens, units};
    endfunction

    logic       w_zero;
    logic       w_last;
    logic [7:0] w_dec_cs;
    logic [7:0] w_dec_sec;
    logic [7:0] w_dec_min;
    logic [7:0] w_min_clamped;
    logic [7:0] w_sec_clamped;

    assign w_zero = (r_min == 8'h00) && (r_sec == 8'h00) && (r_cs == 8'h00);
    // 00:00.01 is the final decrement; it triggers expiry on that edge.
    assign w_last = (r_min == 8'h00) && (r_sec == 8'h00) && (r_cs == 8'h01);

    assign w_dec_cs  = dec_pair(r_cs, 4'd9);
    assign w_dec_sec = (r_cs == 8'h00) ? dec_pair(r_sec, 4'd5) : r_sec;
    assign w_dec_min = (r_cs == 8'h00 && r_sec == 8'h00) ? dec_pair(r_min, 4'd9) : r_min;

    assign w_min_clamped = {clamp_digit(i_min_in[7:4], 4'd9), clamp_digit(i_min_in[3:0], 4'd9)};
    assign w_sec_clamped = {clamp_digit(i_sec_in[7:4], 4'd5), clamp_digit(i_sec_in[3:0], 4'd9)};

    always_comb begin
        w_state_nxt     = r_state;
        w_min_nxt       = r_min;
        w_sec_nxt       = r_sec;
        w_cs_nxt        = r_cs;
        w_done_nxt      = 1'b0;
        w_alarm_nxt     = r_alarm;
        w_alarm_cnt_nxt = r_alarm_cnt;

        if (r_alarm) begin
            if (r_alarm_cnt == '0) begin
                w_alarm_nxt = 1'b0;
            end else begin
                w_alarm_cnt_nxt = r_alarm_cnt - 1'b1;
            end
        end

        case (r_state)
            ST_IDLE, ST_PAUSED: begin
                if (i_load) begin
                    w_min_nxt   = w_min_clamped;
                    w_sec_nxt   = w_sec_clamped;
                    w_cs_nxt    = 8'h00;
                    w_state_nxt = ST_IDLE;
                end else if (i_start && !w_zero) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_pause) begin
                    w_state_nxt = ST_PAUSED;
                end else begin
                    w_cs_nxt  = w_dec_cs;
                    w_sec_nxt = w_dec_sec;
                    w_min_nxt = w_dec_min;
                    if (w_last) begin
                        w_state_nxt     = ST_EXPIRED;
                        w_done_nxt      = 1'b1;
                        w_alarm_nxt     = 1'b1;
                        w_alarm_cnt_nxt = ALARM_RELOAD;
                    end
                end
            end
            ST_EXPIRED: begin
                if (i_load) begin
                    w_min_nxt       = w_min_clamped;
                    w_sec_nxt       = w_sec_clamped;
                    w_cs_nxt        = 8'h00;
                    w_state_nxt     = ST_IDLE;
                    w_alarm_nxt     = 1'b0;
                    w_alarm_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk100hz) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_min       <= 8'h00;
            r_sec       <= 8'h00;
            r_cs        <= 8'h00;
            r_done      <= 1'b0;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_min       <= w_min_nxt;
            r_sec       <= w_sec_nxt;
            r_cs        <= w_cs_nxt;
            r_done      <= w_done_nxt;
            r_alarm     <= w_alarm_nxt;
            r_alarm_cnt <= w_alarm_cnt_nxt;
        end
    end

    assign o_min     = r_min;
    assign o_sec     = r_sec;
    assign o_cs      = r_cs;
    assign o_running = (r_state == ST_RUN);
    assign o_done    = r_done;
    assign o_alarm   = r_alarm;

endmodule
